// File: rtl/div_unit_pkg.sv
// Shared constants for the execute-stage divider: FSM encodings, width and
// the divide-by-zero result, alongside the controller's divide opcode/funct codes.
package div_unit_pkg;
  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
endpackage

// File: rtl/div_unit_if.sv
// Execute-stage divide request/response bundle. start is accepted only in IDLE;
// ready is a one-cycle result-valid pulse; stall holds F/D/E while busy.
interface div_unit_if #(parameter int WIDTH = 32) ();
  logic             start;
  logic             signed_div;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       state;

  modport master (
    output start, signed_div, cancel, a, b,
    input  stall, ready, hi, lo, state
  );

  modport slave (
    input  start, signed_div, cancel, a, b,
    output stall, ready, hi, lo, state
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring shift-subtract iteration: shift {rem,quo} left, try subtracting
// the divisor, keep the result and set the quotient bit when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, divisor};

  // rem < divisor keeps rem_sh below 2*divisor, so a non-borrowing trial fits WIDTH bits.
  assign rem_next = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider: magnitudes are divided by the unsigned core and
// signs are restored as the result is registered into hi (remainder) / lo (quotient).
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic      clk,
  input logic      rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic             sign_q, sign_r;
  logic [WIDTH-1:0] hi, lo;
  logic             ready;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_a, neg_b;

  assign neg_a = bus.signed_div & bus.a[WIDTH-1];
  assign neg_b = bus.signed_div & bus.b[WIDTH-1];
  assign a_mag = neg_a ? -bus.a : bus.a;
  assign b_mag = neg_b ? -bus.b : bus.b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DIV_IDLE;
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      ready   <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (bus.cancel) begin
        state <= DIV_IDLE;
        count <= '0;
      end else begin
        case (state)
          DIV_IDLE: begin
            if (bus.start) begin
              if (bus.b == '0) begin
                // Divide by zero: raw dividend as remainder, all-ones quotient.
                hi    <= bus.a;
                lo    <= WIDTH'(DIV_ZERO_QUO);
                ready <= 1'b1;
                state <= DIV_DONE;
              end else begin
                quo     <= a_mag;
                divisor <= b_mag;
                rem     <= '0;
                sign_q  <= neg_a ^ neg_b;
                sign_r  <= neg_a;
                count   <= CW'(WIDTH);
                state   <= DIV_RUN;
              end
            end
          end
          DIV_RUN: begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count - 1'b1;
            if (count == CW'(1)) begin
              // Sign fix-up lands with ready so DONE presents the final result.
              hi    <= sign_r ? -rem_next : rem_next;
              lo    <= sign_q ? -quo_next : quo_next;
              ready <= 1'b1;
              state <= DIV_DONE;
            end
          end
          DIV_DONE: state <= DIV_IDLE;
          default:  state <= DIV_IDLE;
        endcase
      end
    end
  end

  assign bus.stall = ((state == DIV_IDLE) && bus.start && !bus.cancel) || (state == DIV_RUN);
  assign bus.ready = ready;
  assign bus.hi    = hi;
  assign bus.lo    = lo;
  assign bus.state = state;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: directed corner cases plus random divides
// against a 64-bit arithmetic reference model.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();
  div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0;
  int last_rdy_cyc = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  logic [2*W-1:0] exp_q[$];
  int             rdy_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic sg);
    longint na, nb, q, r;
    if (bv == '0) return {av, 32'hFFFF_FFFF};
    if (sg) begin
      na = longint'($signed(av));
      nb = longint'($signed(bv));
    end else begin
      na = longint'({32'b0, av});
      nb = longint'({32'b0, bv});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: ready=1 with no outstanding divide (cycle %0d)", cyc);
      end else begin
        logic [2*W-1:0] e;
        int rc;
        e  = exp_q.pop_front();
        rc = rdy_q.pop_front();
        check("hi", bus.hi, e[2*W-1:W]);
        check("lo", bus.lo, e[W-1:0]);
        check("ready_cycle", cyc, rc);
        check("stall_in_done", bus.stall, 0);
        last_hi = e[2*W-1:W];
        last_lo = e[W-1:0];
      end
      last_rdy_cyc = cyc;
      n_done++;
    end
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sg,
                       input bit expect_resp);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.a          = av;
    bus.b          = bv;
    bus.signed_div = sg;
    if (expect_resp) begin
      exp_q.push_back(ref_div(av, bv, sg));
      rdy_q.push_back(cyc + ((bv == '0) ? 1 : W + 1));
    end
    #1 check("stall_on_start", bus.stall, 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    #1 check("stall_cycle1", bus.stall, (bv != '0) ? 1 : 0);
  endtask

  task automatic wait_done(input int prev);
    for (int k = 0; k < 60 && n_done == prev; k++) begin
      @(negedge clk);
      #1;
    end
    check("done_timeout", (n_done != prev) ? 1 : 0, 1);
  endtask

  task automatic run_div(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sg);
    int prev;
    prev = n_done;
    issue(av, bv, sg, 1'b1);
    wait_done(prev);
  endtask

  initial begin
    int first_rdy;
    int prev;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.cancel = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_hi", bus.hi, 0);
    check("reset_lo", bus.lo, 0);
    check("reset_ready", bus.ready, 0);
    check("reset_stall", bus.stall, 0);
    check("reset_state", bus.state, DIV_IDLE);

    // Directed corners
    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_div(32'h1234, 32'd0, 1'b0);
    run_div(32'h1234, 32'd0, 1'b1);

    // Cancel in cycle 10: no result, hi/lo held, stall drops next cycle
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    #1;
    check("cancel_stall", bus.stall, 0);
    check("cancel_state", bus.state, DIV_IDLE);
    check("cancel_hi_held", bus.hi, last_hi);
    check("cancel_lo_held", bus.lo, last_lo);
    repeat (30) @(negedge clk);
    run_div(32'd9, 32'd3, 1'b0);

    // Back-to-back: second start the cycle after DONE
    run_div(32'd1000, 32'd33, 1'b0);
    first_rdy = last_rdy_cyc;
    run_div(32'hFFFF_0000, 32'd5, 1'b1);
    check("b2b_spacing", last_rdy_cyc - first_rdy, 34);

    // Reset in cycle 5 of a divide
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_hi = '0;
    last_lo = '0;
    #1;
    check("rst_mid_state", bus.state, DIV_IDLE);
    check("rst_mid_hi", bus.hi, 0);
    check("rst_mid_lo", bus.lo, 0);
    check("rst_mid_stall", bus.stall, 0);
    check("rst_mid_ready", bus.ready, 0);
    prev = n_done;
    repeat (40) @(negedge clk);
    check("rst_no_ready", n_done, prev);

    // Random divides
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 7);
      ra  = $urandom;
      case (sel)
        0:       rb = '0;
        1, 2:    rb = $urandom_range(1, 20);
        3:       rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      if (sel == 4) ra = $urandom_range(0, 50);
      run_div(ra, rb, 1'($urandom_range(0, 1)));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
